// File: rtl/ev21g1.sv
// ev21g1: three-stage (ID / EX / WB) microcoded datapath with a 32-entry
// register file, 256-word data memory in EX, ALU plus single-step shifter,
// and two registered print ports. No forwarding or interlocks.
module ev21g1 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] input_port0,
    input  logic [31:0] input_port1,
    input  logic [15:0] k,
    input  logic [29:0] microinstruction,
    output logic [31:0] output_port0,
    output logic [31:0] output_port1
);

    localparam int DATA_W = 32;

    // Microinstruction fields
    logic [3:0] f_aluc;
    logic [2:0] f_sh;
    logic       f_kmx, f_read, f_write, f_flip, f_print;
    logic [5:0] f_a, f_b, f_c;

    assign f_aluc  = microinstruction[29:26];
    assign f_sh    = microinstruction[25:23];
    assign f_kmx   = microinstruction[22];
    assign f_read  = microinstruction[21];
    assign f_write = microinstruction[20];
    assign f_a     = microinstruction[19:14];
    assign f_b     = microinstruction[13:8];
    assign f_c     = microinstruction[7:2];
    assign f_flip  = microinstruction[1];
    assign f_print = microinstruction[0];

    logic [DATA_W-1:0] regs [32];
    logic [DATA_W-1:0] mem  [256];

    // ID stage registers
    logic [DATA_W-1:0] a_p0, b_p0;
    logic [15:0]       k_p0;
    logic [3:0]        aluc_p0;
    logic [2:0]        sh_p0;
    logic              kmx_p0, rd_p0, wr_p0, flip_p0, print_p0;
    logic [5:0]        c_p0;

    // EX stage registers
    logic [DATA_W-1:0] res_p1;
    logic [4:0]        c_p1;
    logic              vld_p1;

    logic [DATA_W-1:0] src_a, src_b;
    logic [DATA_W-1:0] opb, alu_out, sh_out, ex_res;

    function automatic logic [DATA_W-1:0] alu_op(input logic [3:0] op,
                                                 input logic [DATA_W-1:0] x,
                                                 input logic [DATA_W-1:0] y);
        logic [DATA_W-1:0] r;
        case (op)
            4'b0000: r = y;
            4'b0001: r = x + y;
            4'b0010: r = x - y;
            4'b0011: r = x & y;
            4'b0100: r = x | y;
            4'b0101: r = x ^ y;
            4'b0110: r = ~x;
            4'b0111: r = x;
            4'b1000: r = x + 32'd1;
            4'b1001: r = x - 32'd1;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] shift_op(input logic [2:0] op,
                                                   input logic [DATA_W-1:0] v);
        logic signed [DATA_W-1:0] sv;
        logic [DATA_W-1:0]        r;
        sv = v;
        case (op)
            3'b000:  r = v;
            3'b001:  r = {v[30:0], 1'b0};
            3'b010:  r = {1'b0, v[31:1]};
            3'b011:  r = sv >>> 1;
            3'b100:  r = {v[30:0], v[31]};
            3'b101:  r = {v[0], v[31:1]};
            3'b110:  r = {v[15:0], v[31:16]};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Source operand select: registers, two input ports, otherwise zero
    always_comb begin
        src_a = '0;
        src_b = '0;
        if (!f_a[5])            src_a = regs[f_a[4:0]];
        else if (f_a == 6'd32)  src_a = input_port0;
        else if (f_a == 6'd33)  src_a = input_port1;
        if (!f_b[5])            src_b = regs[f_b[4:0]];
        else if (f_b == 6'd32)  src_b = input_port0;
        else if (f_b == 6'd33)  src_b = input_port1;
    end

    // ID: latch operands and control; reset turns the slot into a NOP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_p0     <= '0;
            b_p0     <= '0;
            k_p0     <= '0;
            aluc_p0  <= '0;
            sh_p0    <= '0;
            kmx_p0   <= 1'b0;
            rd_p0    <= 1'b0;
            wr_p0    <= 1'b0;
            flip_p0  <= 1'b0;
            print_p0 <= 1'b0;
            c_p0     <= 6'd63;
        end else begin
            a_p0     <= src_a;
            b_p0     <= src_b;
            k_p0     <= k;
            aluc_p0  <= f_aluc;
            sh_p0    <= f_sh;
            kmx_p0   <= f_kmx;
            rd_p0    <= f_read;
            wr_p0    <= f_write;
            flip_p0  <= f_flip;
            print_p0 <= f_print;
            c_p0     <= f_c;
        end
    end

    // ---- ID -> EX boundary ----
    // EX datapath: immediate mux, ALU, shifter, memory read before any write
    always_comb begin
        opb     = kmx_p0 ? {16'h0000, k_p0} : b_p0;
        alu_out = alu_op(aluc_p0, a_p0, opb);
        sh_out  = shift_op(sh_p0, alu_out);
        ex_res  = rd_p0 ? mem[b_p0[7:0]] : sh_out;
    end

    // EX: capture the result and whether it targets a real register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_p1 <= '0;
            c_p1   <= '0;
            vld_p1 <= 1'b0;
        end else begin
            res_p1 <= ex_res;
            c_p1   <= c_p0[4:0];
            vld_p1 <= ~c_p0[5];
        end
    end

    // EX: data memory write of A at B[7:0]; contents are never reset
    always_ff @(posedge clk) begin
        if (wr_p0)
            mem[b_p0[7:0]] <= a_p0;
    end

    // EX: print A to the port chosen by flip; ports otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            output_port0 <= '0;
            output_port1 <= '0;
        end else if (print_p0) begin
            if (flip_p0) output_port1 <= a_p0;
            else         output_port0 <= a_p0;
        end
    end

    // ---- EX -> WB boundary ----
    // WB: register file write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= '0;
        end else if (vld_p1) begin
            regs[c_p1] <= res_p1;
        end
    end

endmodule

// File: tb/tb_ev21g1.sv
// Directed testbench for ev21g1. Register contents are observed by printing
// them through output_port0.
module tb_ev21g1;

    logic        clk;
    logic        rst_n;
    logic [31:0] input_port0, input_port1;
    logic [15:0] k;
    logic [29:0] microinstruction;
    logic [31:0] output_port0, output_port1;

    int checks = 0;
    int errors = 0;

    localparam logic [29:0] NOP = 30'h000000FC;

    ev21g1 dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .input_port0      (input_port0),
        .input_port1      (input_port1),
        .k                (k),
        .microinstruction (microinstruction),
        .output_port0     (output_port0),
        .output_port1     (output_port1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [29:0] mi(input logic [3:0] aluc, input logic [2:0] sh,
                                       input logic kmx, input logic rd, input logic wr,
                                       input logic [5:0] a, input logic [5:0] b,
                                       input logic [5:0] c, input logic flip,
                                       input logic pr);
        return {aluc, sh, kmx, rd, wr, a, b, c, flip, pr};
    endfunction

    // All stimulus tasks start and end on a falling edge.
    task automatic issue(input logic [29:0] ins, input logic [15:0] kv);
        microinstruction = ins;
        k = kv;
        @(negedge clk);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) issue(NOP, 16'h0);
    endtask

    task automatic ld(input logic [5:0] c, input logic [15:0] kv);
        issue(mi(4'h0, 3'b000, 1'b1, 1'b0, 1'b0, 6'd0, 6'd0, c, 1'b0, 1'b0), kv);
    endtask

    task automatic read_reg(input logic [5:0] idx, output logic [31:0] v);
        nops(2);
        issue(mi(4'h0, 3'b000, 1'b0, 1'b0, 1'b0, idx, 6'd0, 6'd63, 1'b0, 1'b1), 16'h0);
        issue(NOP, 16'h0);
        v = output_port0;
    endtask

    task automatic do_reset();
        microinstruction = NOP;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        microinstruction = NOP;
        k = '0;
        input_port0 = '0;
        input_port1 = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (output_port0 !== 32'h0) begin
            errors++;
            $display("FAIL reset_port0 got %h expected %h", output_port0, 32'h0);
        end
        checks++;
        if (output_port1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_port1 got %h expected %h", output_port1, 32'h0);
        end
        rst_n = 1'b1;
        read_reg(6'd31, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL reset_r31 got %h expected %h", v, 32'h0);
        end
    endtask

    task automatic test_mem_basic();
        logic [31:0] v;
        ld(6'd0, 16'h00AA);
        ld(6'd1, 16'h00BB);
        nops(2);
        issue(mi(4'h0, 3'b000, 1'b0, 1'b0, 1'b1, 6'd1, 6'd0, 6'd63, 1'b0, 1'b0), 16'h0);
        issue(mi(4'h0, 3'b000, 1'b0, 1'b1, 1'b0, 6'd0, 6'd0, 6'd2, 1'b0, 1'b0), 16'h0);
        read_reg(6'd2, v);
        checks++;
        if (v !== 32'h000000BB) begin
            errors++;
            $display("FAIL mem_basic_r2 got %h expected %h", v, 32'h000000BB);
        end
    endtask

    task automatic test_rw_same();
        ld(6'd3, 16'h00CC);
        nops(1);
        issue(mi(4'h0, 3'b000, 1'b0, 1'b1, 1'b0, 6'd0, 6'd0, 6'd4, 1'b0, 1'b0), 16'h0);
        issue(mi(4'h0, 3'b000, 1'b0, 1'b0, 1'b1, 6'd3, 6'd0, 6'd63, 1'b0, 1'b0), 16'h0);
        issue(mi(4'h0, 3'b000, 1'b0, 1'b1, 1'b0, 6'd0, 6'd0, 6'd4, 1'b0, 1'b0), 16'h0);
        // first print sees the first read's R4, second sees the post-write read
        issue(mi(4'h0, 3'b000, 1'b0, 1'b0, 1'b0, 6'd4, 6'd0, 6'd63, 1'b0, 1'b1), 16'h0);
        nops(1);
        issue(mi(4'h0, 3'b000, 1'b0, 1'b0, 1'b0, 6'd4, 6'd0, 6'd63, 1'b1, 1'b1), 16'h0);
        nops(2);
        checks++;
        if (output_port0 !== 32'h000000BB) begin
            errors++;
            $display("FAIL rw_first_read got %h expected %h", output_port0, 32'h000000BB);
        end
        checks++;
        if (output_port1 !== 32'h000000CC) begin
            errors++;
            $display("FAIL rw_second_read got %h expected %h", output_port1, 32'h000000CC);
        end
    endtask

    task automatic test_mem_pair();
        logic [31:0] v;
        ld(6'd5, 16'h00DD);
        ld(6'd6, 16'h00EE);
        ld(6'd7, 16'h00F0);
        ld(6'd8, 16'h00F1);
        nops(1);
        issue(mi(4'h0, 3'b000, 1'b0, 1'b0, 1'b1, 6'd5, 6'd7, 6'd63, 1'b0, 1'b0), 16'h0);
        issue(mi(4'h0, 3'b000, 1'b0, 1'b0, 1'b1, 6'd6, 6'd8, 6'd63, 1'b0, 1'b0), 16'h0);
        nops(2);
        issue(mi(4'h0, 3'b000, 1'b0, 1'b1, 1'b0, 6'd0, 6'd7, 6'd10, 1'b0, 1'b0), 16'h0);
        issue(mi(4'h0, 3'b000, 1'b0, 1'b1, 1'b0, 6'd0, 6'd8, 6'd11, 1'b0, 1'b0), 16'h0);
        read_reg(6'd10, v);
        checks++;
        if (v !== 32'h000000DD) begin
            errors++;
            $display("FAIL mem_pair_r10 got %h expected %h", v, 32'h000000DD);
        end
        read_reg(6'd11, v);
        checks++;
        if (v !== 32'h000000EE) begin
            errors++;
            $display("FAIL mem_pair_r11 got %h expected %h", v, 32'h000000EE);
        end
    endtask

    task automatic test_hazard();
        logic [31:0] v;
        logic [29:0] add3;
        logic [31:0] exp_v [3];
        exp_v[0] = 32'd3;
        exp_v[1] = 32'd3;
        exp_v[2] = 32'd8;
        add3 = mi(4'h1, 3'b000, 1'b1, 1'b0, 1'b0, 6'd1, 6'd0, 6'd2, 1'b0, 1'b0);
        for (int gap = 0; gap < 3; gap++) begin
            do_reset();
            ld(6'd1, 16'd5);
            nops(gap);
            issue(add3, 16'd3);
            read_reg(6'd2, v);
            checks++;
            if (v !== exp_v[gap]) begin
                errors++;
                $display("FAIL hazard_gap%0d got %h expected %h", gap, v, exp_v[gap]);
            end
        end
    endtask

    task automatic test_ports();
        do_reset();
        input_port0 = 32'h12345678;
        input_port1 = 32'hCAFEF00D;
        issue(mi(4'h0, 3'b000, 1'b0, 1'b0, 1'b0, 6'd32, 6'd0, 6'd63, 1'b0, 1'b1), 16'h0);
        issue(mi(4'h0, 3'b000, 1'b0, 1'b0, 1'b0, 6'd32, 6'd0, 6'd63, 1'b1, 1'b1), 16'h0);
        checks++;
        if (output_port0 !== 32'h12345678) begin
            errors++;
            $display("FAIL print_port0 got %h expected %h", output_port0, 32'h12345678);
        end
        checks++;
        if (output_port1 !== 32'h0) begin
            errors++;
            $display("FAIL port1_early got %h expected %h", output_port1, 32'h0);
        end
        nops(1);
        checks++;
        if (output_port1 !== 32'h12345678) begin
            errors++;
            $display("FAIL print_port1 got %h expected %h", output_port1, 32'h12345678);
        end
        issue(mi(4'h0, 3'b000, 1'b0, 1'b0, 1'b0, 6'd33, 6'd0, 6'd63, 1'b0, 1'b1), 16'h0);
        issue(mi(4'h0, 3'b000, 1'b0, 1'b0, 1'b0, 6'd40, 6'd0, 6'd63, 1'b1, 1'b1), 16'h0);
        nops(3);
        checks++;
        if (output_port0 !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL print_in1_hold got %h expected %h", output_port0, 32'hCAFEF00D);
        end
        checks++;
        if (output_port1 !== 32'h0) begin
            errors++;
            $display("FAIL print_addr40 got %h expected %h", output_port1, 32'h0);
        end
    endtask

    task automatic test_discard();
        logic [31:0] v;
        ld(6'd30, 16'h1234);
        ld(6'd62, 16'h5555);
        ld(6'd32, 16'h6666);
        read_reg(6'd30, v);
        checks++;
        if (v !== 32'h00001234) begin
            errors++;
            $display("FAIL discard_c62 got %h expected %h", v, 32'h00001234);
        end
        read_reg(6'd0, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL discard_c32 got %h expected %h", v, 32'h0);
        end
    endtask

    task automatic test_alu_shift();
        logic [31:0] v;
        logic [5:0]  dst [9];
        logic [31:0] exp_v [9];
        issue(mi(4'h0, 3'b110, 1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 6'd20, 1'b0, 1'b0), 16'h8001);
        ld(6'd21, 16'h0003);
        ld(6'd19, 16'h7777);
        nops(2);
        issue(mi(4'h1, 3'b011, 1'b0, 1'b0, 1'b0, 6'd20, 6'd21, 6'd22, 1'b0, 1'b0), 16'h0);
        issue(mi(4'h2, 3'b100, 1'b0, 1'b0, 1'b0, 6'd20, 6'd21, 6'd23, 1'b0, 1'b0), 16'h0);
        issue(mi(4'h6, 3'b101, 1'b0, 1'b0, 1'b0, 6'd21, 6'd0,  6'd24, 1'b0, 1'b0), 16'h0);
        issue(mi(4'h5, 3'b010, 1'b0, 1'b0, 1'b0, 6'd20, 6'd21, 6'd25, 1'b0, 1'b0), 16'h0);
        issue(mi(4'h9, 3'b001, 1'b0, 1'b0, 1'b0, 6'd20, 6'd0,  6'd26, 1'b0, 1'b0), 16'h0);
        issue(mi(4'h4, 3'b000, 1'b0, 1'b0, 1'b0, 6'd20, 6'd21, 6'd27, 1'b0, 1'b0), 16'h0);
        issue(mi(4'h8, 3'b000, 1'b0, 1'b0, 1'b0, 6'd21, 6'd0,  6'd28, 1'b0, 1'b0), 16'h0);
        issue(mi(4'h7, 3'b000, 1'b0, 1'b0, 1'b0, 6'd20, 6'd21, 6'd29, 1'b0, 1'b0), 16'h0);
        issue(mi(4'hC, 3'b000, 1'b0, 1'b0, 1'b0, 6'd20, 6'd21, 6'd19, 1'b0, 1'b0), 16'h0);
        dst[0] = 6'd20; exp_v[0] = 32'h80010000;
        dst[1] = 6'd22; exp_v[1] = 32'hC0008001;
        dst[2] = 6'd23; exp_v[2] = 32'h0001FFFB;
        dst[3] = 6'd24; exp_v[3] = 32'h7FFFFFFE;
        dst[4] = 6'd25; exp_v[4] = 32'h40008001;
        dst[5] = 6'd26; exp_v[5] = 32'h0001FFFE;
        dst[6] = 6'd27; exp_v[6] = 32'h80010003;
        dst[7] = 6'd28; exp_v[7] = 32'h00000004;
        dst[8] = 6'd19; exp_v[8] = 32'h00000000;
        for (int i = 0; i < 9; i++) begin
            read_reg(dst[i], v);
            checks++;
            if (v !== exp_v[i]) begin
                errors++;
                $display("FAIL alu_shift_r%0d got %h expected %h", dst[i], v, exp_v[i]);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] v;
        do_reset();
        ld(6'd12, 16'h0050);
        ld(6'd13, 16'h1111);
        ld(6'd14, 16'h2222);
        nops(2);
        issue(mi(4'h0, 3'b000, 1'b0, 1'b0, 1'b1, 6'd13, 6'd12, 6'd63, 1'b0, 1'b0), 16'h0);
        issue(mi(4'h0, 3'b000, 1'b0, 1'b0, 1'b0, 6'd13, 6'd0,  6'd63, 1'b0, 1'b1), 16'h0);
        ld(6'd9, 16'h0099);
        issue(mi(4'h0, 3'b000, 1'b0, 1'b0, 1'b1, 6'd14, 6'd12, 6'd63, 1'b0, 1'b1), 16'h0);
        // R9 load is in EX->WB, the overwriting store/print is in ID->EX
        rst_n = 1'b0;
        #1;
        checks++;
        if (output_port0 !== 32'h0) begin
            errors++;
            $display("FAIL abort_port0 got %h expected %h", output_port0, 32'h0);
        end
        microinstruction = NOP;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ld(6'd12, 16'h0050);
        nops(2);
        issue(mi(4'h0, 3'b000, 1'b0, 1'b1, 1'b0, 6'd0, 6'd12, 6'd15, 1'b0, 1'b0), 16'h0);
        read_reg(6'd15, v);
        checks++;
        if (v !== 32'h00001111) begin
            errors++;
            $display("FAIL abort_mem got %h expected %h", v, 32'h00001111);
        end
        read_reg(6'd9, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL abort_r9 got %h expected %h", v, 32'h0);
        end
        checks++;
        if (output_port1 !== 32'h0) begin
            errors++;
            $display("FAIL abort_port1 got %h expected %h", output_port1, 32'h0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        microinstruction = NOP;
        k = '0;
        input_port0 = '0;
        input_port1 = '0;
        test_reset();
        test_mem_basic();
        test_rw_same();
        test_mem_pair();
        test_hazard();
        test_ports();
        test_discard();
        test_alu_shift();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
